// File: rtl/unsort4_stream.sv
// unsort4_stream: scatters a sorted 4-word frame by tag and replays it in original order 0..3.
// Optional UNSORT4_ORDER_CHECK_EN flags frames whose input values are not non-decreasing.
module unsort4_stream #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_idx,
  output logic         out_last,
  output logic         out_err
);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state;
  logic [1:0] cnt, rd;
  logic [N-1:0] mask;
  logic [W-1:0] buf_q [N];
  logic dup_err, ord_err, acc, done;
  assign acc  = in_valid && state == FILL;
  assign done = out_ready && state == DRAIN && rd == 2'd3;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state   <= FILL;
      cnt     <= '0;
      rd      <= '0;
      mask    <= '0;
      dup_err <= 1'b0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else if (state == FILL) begin
      if (in_valid) begin
        if (mask[in_idx]) dup_err <= 1'b1;
        else begin
          buf_q[in_idx] <= in_data;
          mask[in_idx]  <= 1'b1;
        end
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) state <= DRAIN;
      end
    end else if (out_ready) begin
      rd <= rd + 2'd1;
      if (rd == 2'd3) begin
        state   <= FILL;
        cnt     <= '0;
        mask    <= '0;
        dup_err <= 1'b0;
        for (int i = 0; i < N; i++) buf_q[i] <= '0;
      end
    end
`ifdef UNSORT4_ORDER_CHECK_EN
  logic [W-1:0] prev;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      prev    <= '0;
      ord_err <= 1'b0;
    end else if (done) begin
      prev    <= '0;
      ord_err <= 1'b0;
    end else if (acc) begin
      prev <= in_data;
      if (cnt != 2'd0 && in_data < prev) ord_err <= 1'b1;
    end
`else
  assign ord_err = 1'b0;
`endif
  // Outputs decode registered state only; data is gated so FILL shows zeros.
  assign in_ready  = state == FILL;
  assign out_valid = state == DRAIN;
  assign out_data  = out_valid ? buf_q[rd] : '0;
  assign out_idx   = rd;
  assign out_last  = out_valid && rd == 2'd3;
  assign out_err   = out_valid && (dup_err || ord_err);
endmodule

// File: doc/unsort4_stream.md
Name: unsort4_stream

Overview:
- Receive side of the 4-input sorting network.
- Accepts a sorted 4-word frame serially. Each beat carries a 16-bit value and a 2-bit original-position tag.
- Scatters each word into a frame buffer by its tag, then replays the frame serially in original order 0,1,2,3.
- Sits downstream of the sorter pipeline. Restores the original ordering after rank-based processing and flags malformed frames.

Parameters:
- W, 16, data word width in bits.
- N, 4, words per frame. Fixed at 4; tag width is 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. 0 resets the block; release is synchronous to clock.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_data  input  W  sorted value.
- in_idx  input  2  original position of in_data (0..3).
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_data  output  W  restored value for position out_idx.
- out_idx  output  2  position being emitted (0..3).
- out_last  output  1  high on the beat with out_idx==3.
- out_err  output  1  frame malformed. Constant across the whole drain phase.

Behaviour:
- Reset (reset==0, asynchronous):
  - State FILL; write count 0; read pointer 0; slot-written mask 0000.
  - Frame buffer cleared to 0; err flags 0.
  - Output values during reset: in_ready=1 once reset releases, out_valid=0, out_data=0, out_idx=0, out_last=0, out_err=0.
- State FILL:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready.
  - On accept, if mask[in_idx]==0: write buf[in_idx]=in_data and set mask[in_idx].
  - On accept, if mask[in_idx]==1 (duplicate tag): first write wins, the beat is discarded, dup_err is set.
  - Every accept increments the write count, duplicates included.
  - When the 4th beat is accepted (count==3), the next state is DRAIN.
- State DRAIN:
  - in_ready=0, out_valid=1.
  - out_data=buf[rd], out_idx=rd, out_last=(rd==3), out_err=dup_err | ord_err.
  - Transfer = out_valid & out_ready. Each transfer increments rd.
  - On the transfer with rd==3, the next state is FILL and the following are cleared: rd, count, mask, buffer slots, err flags.
  - Outputs hold stable while out_ready==0 (no retraction, no value change).
- Unwritten slots (tag missing because a duplicate displaced it) emit 0. out_err is 1 for that frame.
- Latency:
  - First output beat is valid the cycle after the 4th input accept.
  - Minimum frame period is 8 cycles: 4 fill + 4 drain, with no overlap.
  - in_ready drops the cycle after the 4th accept and returns the cycle after the last output transfer.
- in_valid while in DRAIN: ignored, not accepted. The upstream must hold the beat.
- out_ready while in FILL: ignored.
- Reset mid-frame: partial frame discarded, state returns to the reset values above. No output beat is emitted for the partial frame.
- All outputs are driven from registers or state decode. No combinational path from in_* to out_*.

Optional Feature:
- Macro: UNSORT4_ORDER_CHECK_EN.
- Defined:
  - Register the previous accepted in_data within the frame.
  - If beat k (k>=1) has in_data < previous value (unsigned compare), set ord_err.
  - ord_err clears with the frame and is ORed into out_err.
- Not defined: ord_err is tied to 0. No comparator or previous-value register is present.

Test Plan:
- Basic restore:
  - Stimulus: beats (5,idx2),(9,idx0),(12,idx3),(40,idx1), out_ready=1.
  - Required response: out sequence 9,40,5,12 with idx 0..3, out_last on the 4th beat, out_err=0. The first out_valid is exactly 1 cycle after the 4th accept.
- Backpressure:
  - Stimulus: same frame, out_ready=0 for 5 cycles, then 1.
  - Required response: out_data=9, out_idx=0 held stable for all 5 stalled cycles. in_ready=0 throughout. The full sequence completes afterwards.
- Duplicate tag:
  - Stimulus: beats (1,idx0),(2,idx0),(3,idx2),(4,idx3).
  - Required response: out 1,0,3,4 with out_err=1 on all 4 beats. The next clean frame has out_err=0.
- Back-to-back frames:
  - Stimulus: in_valid held high with 8 beats queued.
  - Required response: in_ready low for 4 cycles between the frames. The second frame is restored correctly with no stale data from the first.
- Async reset:
  - Stimulus: assert reset low after 2 beats accepted, mid-cycle, then release and send a full frame.
  - Required response: out_valid=0 immediately on reset assertion. The full frame is restored with no leftover slots from before the reset.
- Order check (with UNSORT4_ORDER_CHECK_EN defined):
  - Stimulus: values 10,8,20,30 with tags 0..3.
  - Required response: out_err=1.
  - Without the macro, the same stimulus gives out_err=0.
